fp_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes on both sides.
- Next-generation multiplier for the datapath. Adds generic exponent/mantissa widths, round-to-nearest-even, full special-value handling (NaN/Inf/zero) and exception flags.
- Sits between the operand-issue logic and the FP writeback/result FIFO.

---
 rtl/fp_mul_pipe.sv | 181 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier: unpack/classify, significand multiply, normalise,
// then round/pack into the output register. FTZ on inputs and results, RNE rounding.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] y,
   output logic [3:0]           flags
);
   localparam int W    = EXP_W + MAN_W + 1;
   localparam int SW   = MAN_W + 1;
   localparam int PW   = 2 * SW;
   localparam int EW   = EXP_W + 2;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [EW-1:0] BIAS_E  = EW'(BIAS);
   localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {CL_NUM, CL_NAN, CL_INF, CL_ZERO} cls_t;

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- stage 1: unpack / classify ----------------
   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   logic               za, zb, infa, infb, nana, nanb, snana, snanb;
   cls_t               cls_d;
   logic               inv_d;

   assign sa    = a[W-1];
   assign sb    = b[W-1];
   assign ea    = a[MAN_W +: EXP_W];
   assign eb    = b[MAN_W +: EXP_W];
   assign fa    = a[MAN_W-1:0];
   assign fb    = b[MAN_W-1:0];
   // exp==0 covers both true zero and flushed subnormals
   assign za    = (ea == '0);
   assign zb    = (eb == '0);
   assign infa  = (&ea) && (fa == '0);
   assign infb  = (&eb) && (fb == '0);
   assign nana  = (&ea) && (fa != '0);
   assign nanb  = (&eb) && (fb != '0);
   assign snana = nana && !fa[MAN_W-1];
   assign snanb = nanb && !fb[MAN_W-1];

   always_comb begin
      cls_d = CL_NUM;
      inv_d = snana || snanb || (za && infb) || (infa && zb);
      if (nana || nanb || (za && infb) || (infa && zb)) cls_d = CL_NAN;
      else if (infa || infb)                           cls_d = CL_INF;
      else if (za || zb)                               cls_d = CL_ZERO;
   end

   logic           s1_valid, s1_sign, s1_inv;
   logic [EW-1:0]  s1_exp;
   logic [SW-1:0]  s1_ma, s1_mb;
   cls_t           s1_cls;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_sign  <= sa ^ sb;
         s1_exp   <= {2'b00, ea} + {2'b00, eb} - BIAS_E;
         s1_ma    <= {1'b1, fa};
         s1_mb    <= {1'b1, fb};
         s1_cls   <= cls_d;
         s1_inv   <= inv_d;
      end
   end

   // ---------------- stage 2: significand multiply ----------------
   logic           s2_valid, s2_sign, s2_inv;
   logic [EW-1:0]  s2_exp;
   logic [PW-1:0]  s2_prod;
   cls_t           s2_cls;

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_exp   <= s1_exp;
         s2_prod  <= {{SW{1'b0}}, s1_ma} * {{SW{1'b0}}, s1_mb};
         s2_cls   <= s1_cls;
         s2_inv   <= s1_inv;
      end
   end

   // ---------------- stage 3: normalise, extract guard/round/sticky ----------------
   logic [PW-1:0]  norm;
   logic [EW-1:0]  exp_n;

   assign norm  = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
   assign exp_n = s2_exp + {{(EW-1){1'b0}}, s2_prod[PW-1]};

   logic           s3_valid, s3_sign, s3_inv, s3_g, s3_r, s3_s;
   logic [EW-1:0]  s3_exp;
   logic [SW-1:0]  s3_mant;
   cls_t           s3_cls;

   always_ff @(posedge clk) begin
      if (reset) begin
         s3_valid <= 1'b0;
      end else if (en) begin
         s3_valid <= s2_valid;
         s3_sign  <= s2_sign;
         s3_exp   <= exp_n;
         s3_mant  <= norm[PW-1 -: SW];
         s3_g     <= norm[PW-SW-1];
         s3_r     <= norm[PW-SW-2];
         s3_s     <= |norm[PW-SW-3:0];
         s3_cls   <= s2_cls;
         s3_inv   <= s2_inv;
      end
   end

   // ---------------- round to nearest even, range check, pack ----------------
   logic           rnd_up, inexact;
   logic [SW:0]    rsum;
   logic [EW-1:0]  rexp;
   logic [MAN_W-1:0] rfrac;
   logic [W-1:0]   y_d;
   logic [3:0]     flags_d;

   always_comb begin
      rnd_up  = s3_g && (s3_r || s3_s || s3_mant[0]);
      rsum    = {1'b0, s3_mant} + {{SW{1'b0}}, rnd_up};
      rexp    = s3_exp + {{(EW-1){1'b0}}, rsum[SW]};
      rfrac   = rsum[SW] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
      inexact = s3_g || s3_r || s3_s;
      y_d     = '0;
      flags_d = '0;
      case (s3_cls)
         CL_NAN: begin
            y_d     = QNAN;
            flags_d = {s3_inv, 3'b000};
         end
         CL_INF:  y_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         CL_ZERO: y_d = {s3_sign, {(W-1){1'b0}}};
         default: begin
            if ($signed(rexp) >= $signed(EXP_MAX)) begin
               y_d     = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d = 4'b0101;
            end else if (rexp[EW-1] || rexp == '0) begin
               y_d     = {s3_sign, {(W-1){1'b0}}};
               flags_d = 4'b0011;
            end else begin
               y_d     = {s3_sign, rexp[EXP_W-1:0], rfrac};
               flags_d = {3'b000, inexact};
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         y         <= '0;
         flags     <= '0;
      end else if (en) begin
         out_valid <= s3_valid;
         y         <= y_d;
         flags     <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): hand-derived expected products are
// queued on acceptance and compared when results transfer out.
module tb_fp_mul_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 32;
   localparam int NV    = 16;
   localparam int NB    = 6;

   localparam logic [31:0] VA [NV] = '{
      32'h40400000, 32'h3F800001, 32'hBF800000, 32'h7F7FFFFF,
      32'h00800000, 32'h00000000, 32'h7FC00000, 32'h80000000,
      32'h00000001, 32'h3F800001, 32'h3F800003, 32'h7F800000,
      32'h7F800001, 32'h3FC00000, 32'hFF800000, 32'h3F800000};
   localparam logic [31:0] VB [NV] = '{
      32'h40200000, 32'h3F800001, 32'h3FC00000, 32'h40000000,
      32'h00800000, 32'hFF800000, 32'h3F800000, 32'h40000000,
      32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'hFF800000,
      32'h3F800000, 32'h3FC00000, 32'h80000000, 32'h00000001};
   localparam logic [31:0] VY [NV] = '{
      32'h40F00000, 32'h3F800002, 32'hBFC00000, 32'h7F800000,
      32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
      32'h00000000, 32'h3FC00002, 32'h3FC00004, 32'hFF800000,
      32'h7FC00000, 32'h40100000, 32'h7FC00000, 32'h00000000};
   localparam logic [3:0] VF [NV] = '{
      4'b0000, 4'b0001, 4'b0000, 4'b0101,
      4'b0011, 4'b1000, 4'b0000, 4'b0000,
      4'b0000, 4'b0001, 4'b0001, 4'b0000,
      4'b1000, 4'b0000, 4'b1000, 4'b0000};

   localparam logic [31:0] BA [NB] = '{
      32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
   localparam logic [31:0] BY [NB] = '{
      32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

   logic           clk = 1'b0;
   logic           reset, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]   a, b, y;
   logic [3:0]     flags;

   int errors = 0;
   int checks = 0;
   logic [35:0] sb[$];
   int          sb_id[$];

   fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .flags(flags));

   always #5 clk = ~clk;

   // Drive one cycle of inputs, sample handshake state before the edge, then advance.
   task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tb2,
                       input logic ordy, output logic acc, output logic ov,
                       output logic ir, output logic [31:0] gy, output logic [3:0] gf);
      in_valid  = iv;
      a         = ta;
      b         = tb2;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      ov  = out_valid;
      ir  = in_ready;
      gy  = y;
      gf  = flags;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
      checks++;
      if (flags !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      sb.delete();
      sb_id.delete();
   endtask

   task automatic test_latency();
      in_valid = 1'b1; a = 32'h40400000; b = 32'h40200000; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept in_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== (k == 3)) begin
            errors++;
            $display("FAIL lat_valid_edge%0d got %b want %b", k, out_valid, (k == 3));
         end
      end
      checks++;
      if (y !== 32'h40F00000) begin errors++; $display("FAIL lat_y got %h want 40F00000", y); end
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL lat_flags got %b want 0000", flags); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_single got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_vectors();
      int idx = 0;
      int got_n = 0;
      int cyc = 0;
      logic acc, ov, ir, iv, ordy;
      logic [31:0] gy, ta, tb2;
      logic [3:0] gf;
      logic [35:0] e;
      int eid;
      while (got_n < NV && cyc < 300) begin
         iv   = (idx < NV) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         ta   = (idx < NV) ? VA[idx] : 32'h0;
         tb2  = (idx < NV) ? VB[idx] : 32'h0;
         step(iv, ta, tb2, ordy, acc, ov, ir, gy, gf);
         if (acc) begin
            sb.push_back({VY[idx], VF[idx]});
            sb_id.push_back(idx);
            idx++;
         end
         if (ov && ordy) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL vec_unexpected got %h/%b want no result", gy, gf);
            end else begin
               e   = sb.pop_front();
               eid = sb_id.pop_front();
               if ({gy, gf} !== e) begin
                  errors++;
                  $display("FAIL vec%0d y/flags got %h/%b want %h/%b", eid, gy, gf, e[35:4], e[3:0]);
               end
            end
            got_n++;
         end
         cyc++;
      end
      checks++;
      if (got_n != NV) begin errors++; $display("FAIL vec_count got %0d want %0d", got_n, NV); end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int got_n = 0;
      logic acc, ov, ir, ordy, prev_stall;
      logic [31:0] gy, prev_y;
      logic [3:0] gf, prev_f;
      logic [35:0] e;
      prev_stall = 1'b0; prev_y = '0; prev_f = '0;
      for (int c = 0; c < 60 && got_n < NB; c++) begin
         ordy = !(c >= 4 && c <= 8);
         step(idx < NB, (idx < NB) ? BA[idx] : 32'h0, 32'h40000000, ordy, acc, ov, ir, gy, gf);
         if (acc) begin
            sb.push_back({BY[idx], 4'b0000});
            idx++;
         end
         if (ov && !ordy) begin
            checks++;
            if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, ir); end
         end
         if (prev_stall) begin
            checks++;
            if ({gy, gf} !== {prev_y, prev_f}) begin
               errors++;
               $display("FAIL bp_hold cyc%0d got %h/%b want %h/%b", c, gy, gf, prev_y, prev_f);
            end
         end
         if (ov && ordy) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL bp_unexpected got %h want no result", gy);
            end else begin
               e = sb.pop_front();
               if ({gy, gf} !== e) begin
                  errors++;
                  $display("FAIL bp_result%0d got %h/%b want %h/%b", got_n, gy, gf, e[35:4], e[3:0]);
               end
            end
            got_n++;
         end
         prev_stall = ov && !ordy;
         prev_y = gy;
         prev_f = gf;
      end
      checks++;
      if (got_n != NB || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_count got %0d delivered (%0d queued) want %0d", got_n, sb.size(), NB);
      end
   endtask

   task automatic test_reset_midstream();
      logic acc, ov, ir;
      logic [31:0] gy;
      logic [3:0] gf;
      int stale = 0;
      step(1'b1, 32'h3F800000, 32'h40000000, 1'b1, acc, ov, ir, gy, gf);
      step(1'b1, 32'h40400000, 32'h40000000, 1'b1, acc, ov, ir, gy, gf);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", in_ready); end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, acc, ov, ir, gy, gf);
         if (ov) stale++;
      end
      checks++;
      if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d results want 0", stale); end
      in_valid = 1'b1; a = 32'h3FC00000; b = 32'h3FC00000; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== (k == 3)) begin
            errors++;
            $display("FAIL mid_lat_edge%0d got %b want %b", k, out_valid, (k == 3));
         end
      end
      checks++;
      if (y !== 32'h40100000 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL mid_new_result got %h/%b want 40100000/0000", y, flags);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_backpressure();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
